iomem_slot_ctrl: RTL
====================

// Module: iomem_slot_ctrl
// PURPOSE
//  Sequences the PicoSoC iomem bus across NUM_SLOTS memory-mapped peripherals (GPIO/LED, PWM, timers).
//  Decodes page BASE_PAGE into 1 MiB slots, drives one slot at a time and returns its rdata/ready to the core.
//  Every iomem access completes: unmapped addresses and stalled slaves return ERR_RDATA with an error pulse.
//  Sits between the picosoc iomem port and the board-level peripheral blocks in the top level.
// PARAMETERS
//  NUM_SLOTS       4       number of peripheral slots, 1..16; slot index = iomem_addr[23:20]
//  BASE_PAGE       8'h03   iomem_addr[31:24] value decoded by this block
//  TIMEOUT_CYCLES  255     max cycles s_valid stays high before forced error completion, 1..65535
// PORTS
//  clk          in   1            system clock
//  resetn       in   1            asynchronous active-low reset
//  iomem_valid  in   1            core request; held until iomem_ready
//  iomem_ready  out  1            one-cycle completion strobe
//  iomem_wstrb  in   4            byte write strobes; 0 = read
//  iomem_addr   in   32           byte address
//  iomem_wdata  in   32           write data
//  iomem_rdata  out  32           read data, valid while iomem_ready=1
//  s_valid      out  NUM_SLOTS    one-hot slot request
//  s_ready      in   NUM_SLOTS    slot completion, one per slot
//  s_addr       out  20           latched iomem_addr[19:0], shared by all slots
//  s_wstrb      out  4            latched strobes, shared
//  s_wdata      out  32           latched write data, shared
//  s_rdata      in   32*NUM_SLOTS slot k read data at [32k+31:32k]
//  err_irq      out  1            one-cycle pulse on error completion
//  err_addr     out  32           address of the most recent error access
// BEHAVIOUR
//  - Async reset: state IDLE; all outputs 0; internal latches and timeout counter 0.
//  - FSM IDLE -> ACCESS -> RESP -> IDLE; IDLE -> RESP directly on a decode error.
//  - IDLE: when iomem_valid=1 and iomem_ready=0, latch addr/wstrb/wdata.
//    Page==BASE_PAGE and slot<NUM_SLOTS: next cycle s_valid[slot]=1 (ACCESS), counter cleared.
//    Otherwise: decode error, go to RESP; s_valid never asserts and writes are dropped.
//  - ACCESS: s_valid and the s_* buses stay stable.
//    s_ready[slot]=1: capture s_rdata[slot], drop s_valid next cycle, go to RESP (ok).
//    Counter reaches TIMEOUT_CYCLES-1 without ready: drop s_valid, go to RESP (error).
//  - s_ready and timeout in the same cycle: ready wins, no error. s_ready of unselected slots is ignored.
//  - RESP: iomem_ready=1 for exactly one cycle; iomem_rdata = captured data (ok) or ERR_RDATA=32'hFFFF_FFFF (error).
//    Error completions also pulse err_irq and load err_addr in the same cycle.
//    iomem_rdata returns to 0 in the following cycle.
//  - Latency, valid sampled at cycle 0 and slave ready at cycle k>=1 (k=1 = first s_valid cycle):
//    iomem_ready rises at cycle k+1, so a zero-wait slave gives a 2-cycle completion.
//    A decode error gives iomem_ready at cycle 1.
//  - IDLE never starts a new access in the cycle after RESP; no back-to-back double issue.
//  - iomem_valid falling mid-access is a protocol violation; the access still completes normally.
//  - Reset asserted mid-access: s_valid and iomem_ready clear immediately, and the slave sees the access aborted.
//  - Counter is 16 bits, saturating, and runs only in ACCESS.
// STRUCTURE
//  - Package iomem_pkg: state encoding (IDLE/ACCESS/RESP), SLOT_MSB=23, SLOT_LSB=20, PAGE_MSB=31, PAGE_LSB=24,
//    ERR_RDATA constant.
//  - One sub-module, iomem_watchdog: clear/enable/limit inputs and an expired output; it owns the timeout counter.
//  - Slot read mux and one-hot decode stay in this module.
// TESTING
//  - Write 0x0300_0000, wstrb=4'hF, wdata=0x000000A5, slot0 ready at cycle 1:
//    s_valid=4'b0001 and s_wdata=0xA5; iomem_ready at cycle 2; no err_irq.
//  - Read 0x0320_0010, slot2 ready after 3 wait cycles with rdata 0x1234_5678:
//    s_addr=0x00010; iomem_rdata=0x1234_5678 at cycle 5.
//  - Read 0x0350_0000 with NUM_SLOTS=4:
//    no s_valid; iomem_ready at cycle 1 with rdata 0xFFFF_FFFF; err_irq pulse; err_addr=0x0350_0000.
//  - TIMEOUT_CYCLES=8, slot1 never ready: s_valid high for exactly 8 cycles, then error completion.
//    Repeat with ready on the 8th cycle: normal completion with no error.
//  - Assert resetn=0 during ACCESS: s_valid=0 and iomem_ready=0 asynchronously.
//    After release, a fresh read of slot0 completes normally.
//  - 100 random back-to-back reads/writes over all slots, random wait states, compared against a scoreboard:
//    exactly one iomem_ready per request and at most one s_valid bit high at any time.

Source files
------------

// File: rtl/iomem_pkg.sv
// Shared types and constants for the iomem slot controller.
package iomem_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned STRB_W  = 4;
    localparam int unsigned SADDR_W = 20;
    localparam int unsigned SLOT_W  = 4;
    localparam int unsigned PAGE_W  = 8;
    localparam int unsigned CNT_W   = 16;

    localparam int unsigned SLOT_MSB = 23;
    localparam int unsigned SLOT_LSB = 20;
    localparam int unsigned PAGE_MSB = 31;
    localparam int unsigned PAGE_LSB = 24;

    localparam logic [DATA_W-1:0] ERR_RDATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Request payload latched from the core and replayed to the slots.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [STRB_W-1:0] wstrb;
        logic [DATA_W-1:0] wdata;
    } iomem_req_t;

endpackage

// File: rtl/iomem_watchdog.sv
// Saturating access-duration counter; flags the cycle in which the limit is reached.
module iomem_watchdog
    import iomem_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired_c
);

    logic [CNT_W-1:0] cnt_q;

    // Counter clears on request, otherwise counts up while enabled and sticks at all-ones.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // The limit-th enabled cycle is the last one the slave gets.
    always_comb begin
        expired_c = enable && (cnt_q == (limit - CNT_W'(1)));
    end

endmodule

// File: rtl/iomem_slot_ctrl.sv
// Routes picosoc iomem accesses to one of NUM_SLOTS 1 MiB peripheral slots.
module iomem_slot_ctrl
    import iomem_pkg::*;
#(
    parameter int unsigned        NUM_SLOTS      = 4,
    parameter logic [PAGE_W-1:0]  BASE_PAGE      = 8'h03,
    parameter int unsigned        TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          iomem_valid,
    output logic                          iomem_ready,
    input  logic [STRB_W-1:0]             iomem_wstrb,
    input  logic [ADDR_W-1:0]             iomem_addr,
    input  logic [DATA_W-1:0]             iomem_wdata,
    output logic [DATA_W-1:0]             iomem_rdata,
    output logic [NUM_SLOTS-1:0]          s_valid,
    input  logic [NUM_SLOTS-1:0]          s_ready,
    output logic [SADDR_W-1:0]            s_addr,
    output logic [STRB_W-1:0]             s_wstrb,
    output logic [DATA_W-1:0]             s_wdata,
    input  logic [DATA_W*NUM_SLOTS-1:0]   s_rdata,
    output logic                          err_irq,
    output logic [ADDR_W-1:0]             err_addr
);

    state_e                 state_q, state_d;
    iomem_req_t             req_q;
    logic [SLOT_W-1:0]      slot_q;
    logic [NUM_SLOTS-1:0]   s_valid_q, s_valid_d;
    logic                   ready_q, ready_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic                   err_irq_q, err_irq_d;
    logic [ADDR_W-1:0]      err_addr_q, err_addr_d;

    logic                   latch_en;
    logic                   wd_clear;
    logic                   wd_en;
    logic                   expired_c;

    logic [SLOT_W-1:0]      slot_in_c;
    logic                   hit_c;
    logic [NUM_SLOTS-1:0]   onehot_c;
    logic                   sel_ready_c;
    logic [DATA_W-1:0]      sel_rdata_c;

    iomem_watchdog u_watchdog (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (wd_clear),
        .enable    (wd_en),
        .limit     (CNT_W'(TIMEOUT_CYCLES)),
        .expired_c (expired_c)
    );

    // Address decode of the incoming request into a slot hit and one-hot select.
    always_comb begin
        slot_in_c = iomem_addr[SLOT_MSB:SLOT_LSB];
        hit_c     = (iomem_addr[PAGE_MSB:PAGE_LSB] == BASE_PAGE) &&
                    ({1'b0, slot_in_c} < 5'(NUM_SLOTS));
        onehot_c  = '0;
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            onehot_c[k] = (slot_in_c == SLOT_W'(k));
        end
    end

    // Ready/rdata mux for the latched slot; other slots' ready lines are ignored.
    always_comb begin
        sel_ready_c = 1'b0;
        sel_rdata_c = '0;
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            if (slot_q == SLOT_W'(k)) begin
                sel_ready_c = s_ready[k];
                sel_rdata_c = s_rdata[DATA_W*k +: DATA_W];
            end
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_d    = state_q;
        s_valid_d  = '0;
        ready_d    = 1'b0;
        rdata_d    = '0;
        err_irq_d  = 1'b0;
        err_addr_d = err_addr_q;
        latch_en   = 1'b0;
        wd_clear   = 1'b0;
        wd_en      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (iomem_valid && !ready_q) begin
                    latch_en = 1'b1;
                    if (hit_c) begin
                        state_d   = ST_ACCESS;
                        s_valid_d = onehot_c;
                        wd_clear  = 1'b1;
                    end else begin
                        state_d    = ST_RESP;
                        ready_d    = 1'b1;
                        rdata_d    = ERR_RDATA;
                        err_irq_d  = 1'b1;
                        err_addr_d = iomem_addr;
                    end
                end
            end
            ST_ACCESS: begin
                wd_en     = 1'b1;
                s_valid_d = s_valid_q;
                if (sel_ready_c) begin
                    state_d   = ST_RESP;
                    s_valid_d = '0;
                    ready_d   = 1'b1;
                    rdata_d   = sel_rdata_c;
                end else if (expired_c) begin
                    state_d    = ST_RESP;
                    s_valid_d  = '0;
                    ready_d    = 1'b1;
                    rdata_d    = ERR_RDATA;
                    err_irq_d  = 1'b1;
                    err_addr_d = req_q.addr;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            s_valid_q  <= '0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            err_irq_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            s_valid_q  <= s_valid_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            err_irq_q  <= err_irq_d;
            err_addr_q <= err_addr_d;
        end
    end

    // Request latch, loaded when IDLE accepts a core request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_q  <= '0;
            slot_q <= '0;
        end else if (latch_en) begin
            req_q  <= '{addr: iomem_addr, wstrb: iomem_wstrb, wdata: iomem_wdata};
            slot_q <= slot_in_c;
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign s_valid     = s_valid_q;
    assign s_addr      = req_q.addr[SADDR_W-1:0];
    assign s_wstrb     = req_q.wstrb;
    assign s_wdata     = req_q.wdata;
    assign err_irq     = err_irq_q;
    assign err_addr    = err_addr_q;

endmodule
